// File: rtl/keccak_ctrl_pkg.sv
// keccak_ctrl_pkg: shared widths and controller state for the keccak arbiter
package keccak_ctrl_pkg;
  localparam int WORD_W = 64;
  localparam int HASH_W = 512;
  localparam int BYTE_NUM_W = 3;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after the previous owner
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         any
);
  logic [W-1:0] idx;
  // scan last+1, last+2, ... wrapping, and keep the first requester found
  always_comb begin
    grant = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(last) + k) % N);
      if (!any && req[idx]) begin
        grant = idx;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/keccak_arbiter.sv
// keccak_arbiter: shares one keccak core between N_REQ requesters, one message per grant
module keccak_arbiter
  import keccak_ctrl_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [WORD_W*N_REQ-1:0]     req_data,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [BYTE_NUM_W*N_REQ-1:0] req_byte_num,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [HASH_W-1:0]           rsp_hash,
  output logic                        busy,
  output logic [IDX_W-1:0]            grant_id,
  output logic                        core_reset,
  output logic [WORD_W-1:0]           core_in,
  output logic                        core_in_ready,
  output logic                        core_is_last,
  output logic [BYTE_NUM_W-1:0]       core_byte_num,
  input  logic                        core_buffer_full,
  input  logic [HASH_W-1:0]           core_out,
  input  logic                        core_out_ready
);
  state_t state;
  logic [IDX_W-1:0] last_grant, gid, pick;
  logic [N_REQ-1:0] rsp_q;
  logic [HASH_W-1:0] hash_q;
  logic any_req, feed, sel_last, accept;
  logic [WORD_W-1:0] sel_data;
  logic [BYTE_NUM_W-1:0] sel_bn;

  rr_arbiter #(.N(N_REQ), .W(IDX_W)) u_rr (
    .req(req_valid),
    .last(last_grant),
    .grant(pick),
    .any(any_req)
  );

  // the owner's word stream is muxed straight through to the core while feeding
  assign feed = reset_n & (state == S_FEED);
  assign sel_data = req_data[WORD_W*gid +: WORD_W];
  assign sel_last = req_last[gid];
  assign sel_bn = req_byte_num[BYTE_NUM_W*gid +: BYTE_NUM_W];
  assign accept = feed & req_valid[gid] & ~core_buffer_full;
  assign req_ready = accept ? N_REQ'(1) << gid : '0;
  assign core_in_ready = accept;
  assign core_in = feed ? sel_data : '0;
  assign core_is_last = feed & sel_last;
  assign core_byte_num = core_is_last ? sel_bn : '0;
  // the core is cleared together with the arbiter and before every message
  assign core_reset = ~reset_n | (state == S_CLR);
  // registered outputs read as zero while reset is held
  assign busy = reset_n & (state != S_IDLE);
  assign grant_id = reset_n ? gid : '0;
  assign rsp_valid = reset_n ? rsp_q : '0;
  assign rsp_hash = reset_n ? hash_q : '0;

  // one message per grant: pick, clear core, stream words, await digest, respond
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      gid <= '0;
      hash_q <= '0;
      rsp_q <= '0;
    end else begin
      rsp_q <= '0;
      case (state)
        S_IDLE: if (any_req) begin
          gid <= pick;
          state <= S_CLR;
        end
        S_CLR: state <= S_FEED;
        S_FEED: if (accept && sel_last) state <= S_WAIT;
        S_WAIT: if (core_out_ready) begin
          hash_q <= core_out;
          rsp_q <= N_REQ'(1) << gid;
          state <= S_DONE;
        end
        S_DONE: begin
          last_grant <= gid;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
